// File: rtl/crt_sync_decoder_pkg.sv
// rtl/crt_sync_decoder_pkg.sv - state encoding, default width and sync-normalisation helper
package crt_timing_pkg;

   localparam int CRT_W_DEFAULT = 10;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } crt_state_t;

   // Maps a raw sync level onto active-high regardless of pulse polarity.
   function automatic logic sync_normalise(input logic level, input logic active_low);
      return active_low ? ~level : level;
   endfunction

endpackage

// File: rtl/crt_sync_decoder_if.sv
// rtl/crt_sync_decoder_if.sv - sync inputs and decoded timing outputs (CRT_DECODE_ERRCNT_EN adds err_count)
interface crt_sync_decoder_if #(
   parameter int W = 10
);
   logic         pixel_tick;
   logic         hsync;
   logic         vsync;
   logic [W-1:0] xpos;
   logic [W-1:0] ypos;
   logic [W-1:0] line_total;
   logic [W-1:0] hsync_width;
   logic [W-1:0] frame_lines;
   logic         locked;
   logic         frame_start;
   logic         timing_error;
`ifdef CRT_DECODE_ERRCNT_EN
   logic [7:0]   err_count;

   modport master (
      output pixel_tick, hsync, vsync,
      input  xpos, ypos, line_total, hsync_width, frame_lines,
      input  locked, frame_start, timing_error, err_count
   );

   modport slave (
      input  pixel_tick, hsync, vsync,
      output xpos, ypos, line_total, hsync_width, frame_lines,
      output locked, frame_start, timing_error, err_count
   );
`else
   modport master (
      output pixel_tick, hsync, vsync,
      input  xpos, ypos, line_total, hsync_width, frame_lines,
      input  locked, frame_start, timing_error
   );

   modport slave (
      input  pixel_tick, hsync, vsync,
      output xpos, ypos, line_total, hsync_width, frame_lines,
      output locked, frame_start, timing_error
   );
`endif
endinterface

// File: rtl/crt_sync_decoder_edge_sampler.sv
// rtl/crt_sync_decoder_edge_sampler.sv - tick-gated sync sampling with leading/trailing edge detection
module crt_edge_sampler
   import crt_timing_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic tick,
   input  logic sync,
   output logic active,
   output logic lead,
   output logic trail
);

   logic cur_raw;
   logic prev_raw;
   logic cur_act;
   logic prev_act;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_raw  <= ACTIVE_LOW;
         prev_raw <= ACTIVE_LOW;
      end else if (tick) begin
         cur_raw  <= sync;
         prev_raw <= cur_raw;
      end
   end

   assign cur_act  = sync_normalise(cur_raw, ACTIVE_LOW);
   assign prev_act = sync_normalise(prev_raw, ACTIVE_LOW);

   // Edges are only meaningful to the consumer on a tick, so qualify them here.
   assign active = cur_act;
   assign lead   = tick & cur_act & ~prev_act;
   assign trail  = tick & ~cur_act & prev_act;

endmodule

// File: rtl/crt_sync_decoder.sv
// rtl/crt_sync_decoder.sv - CRT sync decoder: position counters, measurements and lock FSM (CRT_DECODE_ERRCNT_EN adds err_count)
module crt_sync_decoder
   import crt_timing_pkg::*;
#(
   parameter int W               = CRT_W_DEFAULT,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic              clock,
   input  logic              reset,
   crt_sync_decoder_if.slave bus
);

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (&v) ? v : v + W'(1);
   endfunction

   logic h_active;
   logic h_lead;
   logic h_trail;
   logic v_active;
   logic v_lead;
   logic v_trail;
   logic unused_vs;

   logic [W-1:0] pix_cnt;
   logic [W-1:0] width_cnt;
   logic [W-1:0] ypos_r;
   logic [W-1:0] line_total_r;
   logic [W-1:0] hsync_width_r;
   logic [W-1:0] frame_lines_r;
   logic         frame_start_r;

   crt_state_t   state;
   crt_state_t   state_n;
   logic [W-1:0] ref_line;
   logic [W-1:0] ref_line_n;
   logic [W-1:0] ref_lines;
   logic [W-1:0] ref_lines_n;
   logic [2:0]   match_cnt;
   logic [2:0]   match_n;
   logic [2:0]   match_inc;
   logic         armed;
   logic         armed_n;
   logic         locked_r;
   logic         locked_n;
   logic         error_r;
   logic         error_n;
   logic [W-1:0] line_meas;
   logic [W-1:0] lines_meas;

   crt_edge_sampler #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs (
      .clock  (clock),
      .reset  (reset),
      .tick   (bus.pixel_tick),
      .sync   (bus.hsync),
      .active (h_active),
      .lead   (h_lead),
      .trail  (h_trail)
   );

   crt_edge_sampler #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs (
      .clock  (clock),
      .reset  (reset),
      .tick   (bus.pixel_tick),
      .sync   (bus.vsync),
      .active (v_active),
      .lead   (v_lead),
      .trail  (v_trail)
   );

   assign unused_vs = v_active ^ v_trail;

   always_ff @(posedge clock) begin
      if (reset) begin
         pix_cnt       <= '0;
         width_cnt     <= '0;
         ypos_r        <= '0;
         line_total_r  <= '0;
         hsync_width_r <= '0;
         frame_lines_r <= '0;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= v_lead;
         if (bus.pixel_tick) begin
            if (h_lead) begin
               line_total_r <= sat_inc(pix_cnt);
               pix_cnt      <= '0;
            end else begin
               pix_cnt <= sat_inc(pix_cnt);
            end

            if (h_trail) begin
               hsync_width_r <= width_cnt;
               width_cnt     <= '0;
            end else if (h_lead) begin
               width_cnt <= W'(1);
            end else if (h_active) begin
               width_cnt <= sat_inc(width_cnt);
            end

            // A coincident vs edge takes priority over the hs line increment.
            if (v_lead) begin
               frame_lines_r <= sat_inc(ypos_r);
               ypos_r        <= '0;
            end else if (h_lead) begin
               ypos_r <= sat_inc(ypos_r);
            end
         end
      end
   end

   // Use the line length being recorded this cycle when hs and vs edges coincide.
   assign line_meas  = h_lead ? sat_inc(pix_cnt) : line_total_r;
   assign lines_meas = sat_inc(ypos_r);
   assign match_inc  = match_cnt + 3'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_SEARCH;
         ref_line  <= '0;
         ref_lines <= '0;
         match_cnt <= '0;
         armed     <= 1'b0;
         locked_r  <= 1'b0;
         error_r   <= 1'b0;
      end else begin
         state     <= state_n;
         ref_line  <= ref_line_n;
         ref_lines <= ref_lines_n;
         match_cnt <= match_n;
         armed     <= armed_n;
         locked_r  <= locked_n;
         error_r   <= error_n;
      end
   end

   always_comb begin
      state_n     = state;
      ref_line_n  = ref_line;
      ref_lines_n = ref_lines;
      match_n     = match_cnt;
      armed_n     = armed;
      locked_n    = locked_r;
      error_n     = 1'b0;
      case (state)
         ST_SEARCH: begin
            if (v_lead) begin
               state_n = ST_MEASURE;
               armed_n = 1'b1;
               // The frame in progress at reset is partial, so it only arms measurement.
               if (armed) begin
                  ref_line_n  = line_meas;
                  ref_lines_n = lines_meas;
                  match_n     = 3'd1;
               end else begin
                  ref_line_n  = '0;
                  ref_lines_n = '0;
                  match_n     = 3'd0;
               end
            end
         end
         ST_MEASURE: begin
            if (v_lead) begin
               if ((line_meas == ref_line) && (lines_meas == ref_lines)) begin
                  match_n = match_inc;
                  if (match_inc >= 3'(LOCK_FRAMES)) begin
                     state_n  = ST_LOCKED;
                     locked_n = 1'b1;
                  end
               end else begin
                  ref_line_n  = line_meas;
                  ref_lines_n = lines_meas;
                  match_n     = 3'd1;
               end
            end
         end
         ST_LOCKED: begin
            if ((h_lead && (line_meas != ref_line)) ||
                (v_lead && (lines_meas != ref_lines))) begin
               error_n  = 1'b1;
               locked_n = 1'b0;
               state_n  = ST_SEARCH;
            end
         end
         default: begin
            state_n  = ST_SEARCH;
            locked_n = 1'b0;
         end
      endcase
   end

`ifdef CRT_DECODE_ERRCNT_EN
   logic [7:0] err_count_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         err_count_r <= '0;
      end else if (error_n && (err_count_r != 8'hFF)) begin
         err_count_r <= err_count_r + 8'd1;
      end
   end

   assign bus.err_count = err_count_r;
`endif

   assign bus.xpos         = pix_cnt;
   assign bus.ypos         = ypos_r;
   assign bus.line_total   = line_total_r;
   assign bus.hsync_width  = hsync_width_r;
   assign bus.frame_lines  = frame_lines_r;
   assign bus.locked       = locked_r;
   assign bus.frame_start  = frame_start_r;
   assign bus.timing_error = error_r;

endmodule

// File: tb/tb_crt_sync_decoder.sv
// tb/tb_crt_sync_decoder.sv - scoreboard bench for crt_sync_decoder (CRT_DECODE_ERRCNT_EN checks err_count)
module tb_crt_sync_decoder;

   localparam int W  = 10;
   localparam int L  = 12;
   localparam int HW = 2;
   localparam int H  = 7;

   typedef struct packed {
      logic [15:0] ex;
      logic [15:0] ey;
      logic        fs;
      logic        te;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   exp_t sb[$];
   exp_t last;
   int   checks = 0;
   int   errors = 0;

   crt_sync_decoder_if #(.W(W)) bus();

   crt_sync_decoder #(.W(W), .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, want);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_x"},  bus.xpos, 0);
      check({pfx, "_y"},  bus.ypos, 0);
      check({pfx, "_lt"}, bus.line_total, 0);
      check({pfx, "_hw"}, bus.hsync_width, 0);
      check({pfx, "_fl"}, bus.frame_lines, 0);
      check({pfx, "_lk"}, bus.locked, 0);
      check({pfx, "_fs"}, bus.frame_start, 0);
      check({pfx, "_te"}, bus.timing_error, 0);
`ifdef CRT_DECODE_ERRCNT_EN
      check({pfx, "_ec"}, bus.err_count, 0);
`endif
   endtask

   // Drive one pixel; the DUT reflects a pixel one tick later, so compare the entry pushed on the previous tick.
   task automatic tick_px(input bit hs_act, input bit vs_act, input bit push,
                          input int ex, input int ey, input bit fs, input bit te);
      exp_t e;
      exp_t f;
      e.ex = 16'(ex);
      e.ey = 16'(ey);
      e.fs = fs;
      e.te = te;
      bus.hsync      = ~hs_act;
      bus.vsync      = ~vs_act;
      bus.pixel_tick = 1'b1;
      if (push) sb.push_back(e);
      @(posedge clock);
      #1;
      bus.pixel_tick = 1'b0;
      if (sb.size() >= 2) begin
         f    = sb.pop_front();
         last = f;
         check("xpos", bus.xpos, f.ex);
         check("ypos", bus.ypos, f.ey);
         check("frame_start", bus.frame_start, f.fs);
         check("timing_error", bus.timing_error, f.te);
      end
      repeat (2) begin
         @(posedge clock);
         #1;
         check("fs_clear", bus.frame_start, 0);
         check("te_clear", bus.timing_error, 0);
      end
   endtask

   task automatic gate_pause();
      int pulses;
      pulses = 0;
      repeat (50) begin
         @(posedge clock);
         #1;
         if (bus.frame_start || bus.timing_error) pulses++;
      end
      check("gate_pulses", pulses, 0);
      check("gate_x",  bus.xpos, last.ex);
      check("gate_y",  bus.ypos, last.ey);
      check("gate_lt", bus.line_total, L);
      check("gate_hw", bus.hsync_width, HW);
      check("gate_fl", bus.frame_lines, H);
      check("gate_lk", bus.locked, 1);
   endtask

   task automatic run_frame(input int glitch, input int pause_line, input int stop_line);
      for (int l = 0; l < H; l++) begin
         int len;
         len = (l == glitch) ? L + 1 : L;
         for (int p = 0; p < len; p++) begin
            tick_px(p < HW, l == 0, 1'b1, p, l, (p == 0) && (l == 0),
                    (glitch >= 0) && (l == glitch + 1) && (p == 0));
            if (l == pause_line && p == 5) gate_pause();
            if (l == stop_line && p == 6) return;
         end
      end
   endtask

   initial begin
      bus.pixel_tick = 1'b0;
      bus.hsync      = 1'b1;
      bus.vsync      = 1'b1;
      reset          = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check_zero("por");

      repeat (3) run_frame(-1, -1, -1);
      check("nom_lt", bus.line_total, L);
      check("nom_hw", bus.hsync_width, HW);
      check("nom_fl", bus.frame_lines, H);
      check("nom_lk", bus.locked, 1);

      run_frame(-1, 2, -1);

      run_frame(3, -1, -1);
      check("glitch_lk", bus.locked, 0);
`ifdef CRT_DECODE_ERRCNT_EN
      check("glitch_ec", bus.err_count, 1);
`endif
      run_frame(-1, -1, -1);
      check("relock_wait", bus.locked, 0);
      run_frame(-1, -1, -1);
      check("relock", bus.locked, 1);

      run_frame(-1, -1, 2);
      check("mid_pre_x", bus.xpos, 5);
      check("mid_pre_y", bus.ypos, 2);
      bus.hsync = 1'b1;
      bus.vsync = 1'b1;
      reset     = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      sb.delete();
      check_zero("mid");

      repeat (3) run_frame(-1, -1, -1);
      check("rec_lk", bus.locked, 1);
      check("rec_lt", bus.line_total, L);
      check("rec_fl", bus.frame_lines, H);

      sb.delete();
      repeat (1100) tick_px(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      check("sat_x",  bus.xpos, (1 << W) - 1);
      check("sat_lk", bus.locked, 1);
      check("sat_lt", bus.line_total, L);
      tick_px(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      check("sat_hold", bus.xpos, (1 << W) - 1);
      bus.pixel_tick = 1'b1;
      @(posedge clock);
      #1;
      bus.pixel_tick = 1'b0;
      check("sat_edge_lt", bus.line_total, (1 << W) - 1);
      check("sat_edge_x",  bus.xpos, 0);
      check("sat_edge_te", bus.timing_error, 1);
      check("sat_edge_lk", bus.locked, 0);
`ifdef CRT_DECODE_ERRCNT_EN
      check("sat_edge_ec", bus.err_count, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
